rift2_wb_bridge: RTL



---
 rtl/rift2_wb_pkg.sv | 32 +++
 rtl/rift2_wb_bridge.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rift2_wb_pkg.sv
// Shared types and constants for the Rift2 Wishbone bridge.
package rift2_wb_pkg;

    // Bridge transfer states
    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StRsp,
        StAck
    } state_e;

    // Address bits [19:8] equal to this select the local CSR bank
    localparam logic [11:0] CsrHitField = 12'hFFF;

    // CSR byte offsets (address bits [7:0])
    localparam logic [7:0] CsrCtrlOff    = 8'h00;
    localparam logic [7:0] CsrStatusOff  = 8'h04;
    localparam logic [7:0] CsrErrAddrOff = 8'h08;

    // Read data returned on aborted transfers
    localparam logic [31:0] TimeoutData = 32'hDEAD_BEEF;
    localparam logic [31:0] ErrData     = 32'hBADB_AD00;

    // STATUS bit indices
    localparam int unsigned StatusTimeoutBit = 0;
    localparam int unsigned StatusErrBit     = 1;

    function automatic logic is_csr_addr(input logic [31:0] adr);
        return adr[19:8] == CsrHitField;
    endfunction

endpackage

// File: rtl/rift2_wb_bridge.sv
// Wishbone classic slave in front of the Rift2 core. Serves a small CSR bank
// (core hold, sticky status, error address) and forwards every other in-window
// access as a valid/ready request/response transaction.
// Optional macro RIFT2_WB_TIMEOUT_EN adds a REQ+RSP timeout guard.
module rift2_wb_bridge
    import rift2_wb_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'h3000_0000,
    parameter logic [31:0] ADDR_MASK   = 32'hFFF0_0000,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        req_valid_o,
    input  logic        req_ready_i,
    output logic [31:0] req_addr_o,
    output logic [31:0] req_wdata_o,
    output logic [3:0]  req_wstrb_o,
    output logic        req_we_o,
    input  logic        rsp_valid_i,
    output logic        rsp_ready_o,
    input  logic [31:0] rsp_rdata_i,
    input  logic        rsp_err_i,
    output logic        core_rst_n_o,
    output logic        irq_o
);

    state_e      state_q;
    logic        ack_q;
    logic [31:0] dat_q;
    logic        req_valid_q;
    logic [31:0] req_addr_q;
    logic [31:0] req_wdata_q;
    logic [3:0]  req_wstrb_q;
    logic        req_we_q;
    logic        rsp_ready_q;
    logic        cyc_lost_q;
    logic        hold_q, hold_d;
    logic        core_rst_n_q;
    logic [1:0]  status_q, status_d;
    logic        irq_q;
    logic [31:0] err_addr_q;

    logic        win_hit;
    logic        csr_fire;
    logic        csr_wr;
    logic        fwd_fire;
    logic        rsp_fire;
    logic        tmo_fire;
    logic        xfer_done;
    logic [31:0] done_data;
    logic [31:0] csr_rdata;
    logic [1:0]  status_set;
    logic [1:0]  status_clr;
    logic        err_load;

`ifdef RIFT2_WB_TIMEOUT_EN
    logic [15:0] tmo_cnt_q;
`else
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = ^16'(TIMEOUT_CYC);
`endif

    assign win_hit = (wbs_adr_i & ADDR_MASK) == ADDR_BASE;

    // CSR read mux; unmapped offsets read as zero
    always_comb begin
        csr_rdata = '0;
        case (wbs_adr_i[7:0])
            CsrCtrlOff:    csr_rdata = {31'b0, hold_q};
            CsrStatusOff:  csr_rdata = {30'b0, status_q};
            CsrErrAddrOff: csr_rdata = err_addr_q;
            default:       csr_rdata = '0;
        endcase
    end

    // Transfer events and CSR next-state; a status set beats a same-cycle W1C
    always_comb begin
        csr_fire = (state_q == StIdle) && wbs_cyc_i && wbs_stb_i && win_hit && !ack_q
                   && is_csr_addr(wbs_adr_i);
        fwd_fire = (state_q == StIdle) && wbs_cyc_i && wbs_stb_i && win_hit && !ack_q
                   && !is_csr_addr(wbs_adr_i);
        csr_wr   = csr_fire && wbs_we_i;
        rsp_fire = (state_q == StRsp) && rsp_valid_i;
`ifdef RIFT2_WB_TIMEOUT_EN
        // A response arriving on the timeout cycle still completes normally
        tmo_fire = ((state_q == StReq) || (state_q == StRsp)) && !rsp_fire
                   && (tmo_cnt_q == 16'(TIMEOUT_CYC));
`else
        tmo_fire = 1'b0;
`endif
        xfer_done = rsp_fire || tmo_fire;

        if (tmo_fire) begin
            done_data = TimeoutData;
        end else if (rsp_err_i) begin
            done_data = ErrData;
        end else if (req_we_q) begin
            done_data = '0;
        end else begin
            done_data = rsp_rdata_i;
        end

        status_set = '0;
        if (rsp_fire && rsp_err_i) status_set[StatusErrBit] = 1'b1;
        if (tmo_fire)              status_set[StatusTimeoutBit] = 1'b1;

        status_clr = '0;
        if (csr_wr && (wbs_adr_i[7:0] == CsrStatusOff) && wbs_sel_i[0]) begin
            status_clr = wbs_dat_i[1:0];
        end
        status_d = (status_q & ~status_clr) | status_set;

        hold_d = hold_q;
        if (csr_wr && (wbs_adr_i[7:0] == CsrCtrlOff) && wbs_sel_i[0]) begin
            hold_d = wbs_dat_i[0];
        end

        err_load = (rsp_fire && rsp_err_i) || tmo_fire;
    end

    // Bridge FSM, CSR bank and all registered outputs
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q      <= StIdle;
            ack_q        <= 1'b0;
            dat_q        <= '0;
            req_valid_q  <= 1'b0;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
            req_wstrb_q  <= '0;
            req_we_q     <= 1'b0;
            rsp_ready_q  <= 1'b0;
            cyc_lost_q   <= 1'b0;
            hold_q       <= 1'b1;
            core_rst_n_q <= 1'b0;
            status_q     <= '0;
            irq_q        <= 1'b0;
            err_addr_q   <= '0;
`ifdef RIFT2_WB_TIMEOUT_EN
            tmo_cnt_q    <= '0;
`endif
        end else begin
            // Ack and read data are single-cycle pulses
            ack_q        <= 1'b0;
            dat_q        <= '0;
            hold_q       <= hold_d;
            core_rst_n_q <= ~hold_d;
            status_q     <= status_d;
            irq_q        <= |status_d;
            if (err_load) err_addr_q <= req_addr_q;

`ifdef RIFT2_WB_TIMEOUT_EN
            if (fwd_fire) begin
                tmo_cnt_q <= '0;
            end else if ((state_q == StReq) || (state_q == StRsp)) begin
                tmo_cnt_q <= tmo_cnt_q + 16'd1;
            end
`endif

            unique case (state_q)
                StIdle: begin
                    if (csr_fire) begin
                        if (!wbs_we_i) dat_q <= csr_rdata;
                        ack_q   <= 1'b1;
                        state_q <= StAck;
                    end else if (fwd_fire) begin
                        req_addr_q  <= wbs_adr_i - ADDR_BASE;
                        req_wdata_q <= wbs_dat_i;
                        req_wstrb_q <= wbs_sel_i;
                        req_we_q    <= wbs_we_i;
                        req_valid_q <= 1'b1;
                        cyc_lost_q  <= 1'b0;
                        state_q     <= StReq;
                    end
                end
                StReq, StRsp: begin
                    // Once the master abandons the cycle, finish quietly
                    if (!wbs_cyc_i) cyc_lost_q <= 1'b1;
                    if (xfer_done) begin
                        req_valid_q <= 1'b0;
                        rsp_ready_q <= 1'b0;
                        if (wbs_cyc_i && !cyc_lost_q) begin
                            ack_q   <= 1'b1;
                            dat_q   <= done_data;
                            state_q <= StAck;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else if ((state_q == StReq) && req_ready_i) begin
                        req_valid_q <= 1'b0;
                        rsp_ready_q <= 1'b1;
                        state_q     <= StRsp;
                    end
                end
                StAck: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign wbs_ack_o    = ack_q;
    assign wbs_dat_o    = dat_q;
    assign req_valid_o  = req_valid_q;
    assign req_addr_o   = req_addr_q;
    assign req_wdata_o  = req_wdata_q;
    assign req_wstrb_o  = req_wstrb_q;
    assign req_we_o     = req_we_q;
    assign rsp_ready_o  = rsp_ready_q;
    assign core_rst_n_o = core_rst_n_q;
    assign irq_o        = irq_q;

endmodule
